// File: rtl/alarm_countdown_timer_if.sv
// Control/status bundle between the alarm FSM (master) and the countdown timer (slave).
// The pause line exists only when ALARM_TIMER_PAUSE_EN is defined.
interface alarm_countdown_timer_if #(
   parameter int VALUE_W = 4
);
   logic               start_timer;
   logic [VALUE_W-1:0] value;
   logic               expired;
   logic               one_hz_enable;
   logic [VALUE_W-1:0] remaining;
`ifdef ALARM_TIMER_PAUSE_EN
   logic               pause;

   modport master (
      output start_timer, value, pause,
      input  expired, one_hz_enable, remaining
   );
   modport slave (
      input  start_timer, value, pause,
      output expired, one_hz_enable, remaining
   );
`else
   modport master (
      output start_timer, value,
      input  expired, one_hz_enable, remaining
   );
   modport slave (
      input  start_timer, value,
      output expired, one_hz_enable, remaining
   );
`endif
endinterface

// File: rtl/alarm_countdown_timer.sv
// Whole-second countdown timer with the system 1 Hz enable for the alarm controller.
// Optional freeze input enabled by defining ALARM_TIMER_PAUSE_EN.
module alarm_countdown_timer #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int VALUE_W  = 4
) (
   input logic                    clock,
   input logic                    reset,
   alarm_countdown_timer_if.slave tmr
);

   localparam int             PS_W   = $clog2(CLK_FREQ);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_FREQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [PS_W-1:0]    prescaler;
   logic [VALUE_W-1:0] remaining_q;
   logic               hold;
   logic               tick;

   function automatic logic [VALUE_W-1:0] sat_dec(input logic [VALUE_W-1:0] x);
      return (x == '0) ? x : x - VALUE_W'(1);
   endfunction

`ifdef ALARM_TIMER_PAUSE_EN
   assign hold = tmr.pause;
`else
   assign hold = 1'b0;
`endif

   // A frozen prescaler must not emit a tick even if parked on its last count.
   assign tick = (prescaler == PS_MAX) && !hold;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         prescaler   <= '0;
         remaining_q <= '0;
      end else if (tmr.start_timer) begin
         prescaler   <= '0;
         remaining_q <= tmr.value;
         state       <= (tmr.value == '0) ? DONE : COUNT;
      end else begin
         if (!hold) begin
            prescaler <= (prescaler == PS_MAX) ? '0 : prescaler + PS_W'(1);
         end
         case (state)
            IDLE: begin
               state <= IDLE;
            end
            COUNT: begin
               if (tick) begin
                  remaining_q <= sat_dec(remaining_q);
                  if (remaining_q <= VALUE_W'(1)) begin
                     state <= DONE;
                  end
               end
            end
            // DONE always retires after one cycle so expired stays a single pulse.
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign tmr.expired       = (state == DONE);
   assign tmr.one_hz_enable = tick;
   assign tmr.remaining     = remaining_q;

endmodule

// File: tb/tb_alarm_countdown_timer.sv
// Randomised bench for alarm_countdown_timer against an elapsed-time reference model.
// Define ALARM_TIMER_PAUSE_EN for both bench and RTL to exercise the pause input.
module tb_alarm_countdown_timer;

   localparam int F  = 10;
   localparam int VW = 4;
`ifdef ALARM_TIMER_PAUSE_EN
   localparam bit HAS_PAUSE = 1'b1;
`else
   localparam bit HAS_PAUSE = 1'b0;
`endif

   logic clock;
   logic reset;

   alarm_countdown_timer_if #(.VALUE_W(VW)) tif ();

   alarm_countdown_timer #(.CLK_FREQ(F), .VALUE_W(VW)) dut (
      .clock (clock),
      .reset (reset),
      .tmr   (tif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // model state: everything is expressed as edge indices and elapsed counts
   int n      = 0;   // rising edges seen
   int anchor = 0;   // edge after which the prescaler was zero
   int pa     = 0;   // paused edges since anchor
   bit active = 0;   // a countdown is outstanding
   int ld     = 0;   // load edge
   int lv     = 0;   // loaded value
   int pl     = 0;   // paused edges while counting since load
   int exp_cnt    = 0;
   int last_exp_n = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_remaining", int'(tif.remaining), 0);
      check("rst_expired", int'(tif.expired), 0);
      check("rst_one_hz", int'(tif.one_hz_enable), 0);
      @(posedge clock);
      n++;
      anchor = n;
      pa     = 0;
      active = 0;
      pl     = 0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic cycle(input bit st, input int v, input bit p);
      bit pe;
      int e;
      int rem_x;
      int exp_x;
      int hz_x;
      pe = p & HAS_PAUSE;
`ifdef ALARM_TIMER_PAUSE_EN
      tif.pause = pe;
`endif
      tif.start_timer = st;
      tif.value       = v[VW-1:0];
      @(posedge clock);
      n++;
      if (st) begin
         active = 1;
         ld     = n;
         lv     = v % 16;
         pl     = 0;
         anchor = n;
         pa     = 0;
      end else if (pe) begin
         pa++;
         if (active && (n - 1) < ld + lv * F + pl) pl++;
      end
      @(negedge clock);
      hz_x  = ((((n - anchor - pa) % F) == F - 1) && !pe) ? 1 : 0;
      rem_x = 0;
      exp_x = 0;
      e     = ld + lv * F + pl;
      if (active) begin
         if (n == e) exp_x = 1;
         else if (n < e) rem_x = lv - (n - ld - pl) / F;
      end
      check("one_hz", int'(tif.one_hz_enable), hz_x);
      check("expired", int'(tif.expired), exp_x);
      check("remaining", int'(tif.remaining), rem_x);
      if (tif.expired) begin
         exp_cnt++;
         last_exp_n = n;
      end
      if (active && n >= e) active = 0;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(1'b0, 0, 1'b0);
   endtask

   int load_n;

   initial begin
      reset           = 1'b0;
      tif.start_timer = 1'b0;
      tif.value       = '0;
`ifdef ALARM_TIMER_PAUSE_EN
      tif.pause       = 1'b0;
`endif
      @(negedge clock);
      do_reset();

      // free-running 1 Hz enable
      exp_cnt = 0;
      idle(25);
      check("free_no_expired", exp_cnt, 0);

      // value 3
      exp_cnt = 0;
      cycle(1'b1, 3, 1'b0);
      load_n = n;
      idle(35);
      check("v3_pulses", exp_cnt, 1);
      check("v3_latency", last_exp_n - load_n, 30);

      // value 0
      exp_cnt = 0;
      cycle(1'b1, 0, 1'b0);
      load_n = n;
      idle(5);
      check("v0_pulses", exp_cnt, 1);
      check("v0_latency", last_exp_n - load_n, 0);

      // restart mid-count
      exp_cnt = 0;
      cycle(1'b1, 5, 1'b0);
      idle(24);
      cycle(1'b1, 2, 1'b0);
      load_n = n;
      idle(30);
      check("restart_pulses", exp_cnt, 1);
      check("restart_latency", last_exp_n - load_n, 20);

      // start held for five cycles
      exp_cnt = 0;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1, 1'b0);
      load_n = n;
      idle(15);
      check("held_pulses", exp_cnt, 1);
      check("held_latency", last_exp_n - load_n, 10);

      // reset in the middle of a count
      exp_cnt = 0;
      cycle(1'b1, 9, 1'b0);
      idle(39);
      do_reset();
      idle(100);
      check("rst_mid_pulses", exp_cnt, 0);

`ifdef ALARM_TIMER_PAUSE_EN
      exp_cnt = 0;
      cycle(1'b1, 2, 1'b0);
      load_n = n;
      idle(5);
      for (int i = 0; i < 7; i++) cycle(1'b0, 0, 1'b1);
      idle(25);
      check("pause_pulses", exp_cnt, 1);
      check("pause_latency", last_exp_n - load_n, 27);
`endif

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 29) == 0, int'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
